axi_timestable_arbiter: RTL and testbench
=========================================

Name: axi_timestable_arbiter

Overview:
Round-robin read arbiter that shares one AXI4-lite read-only path into the times-table block memory (0..7 x 0..7 products) between two requesters. It accepts {a,b} lookup requests, runs a single-outstanding AR/R handshake sequence, and returns the 6-bit product to the granted requester with a one-cycle done pulse. It sits between requester logic and the BMEM AXI4-lite slave. The write channels of the slave are tied off outside this block.

Parameters:
ADDR_SHIFT, 2, left shift applied to the 6-bit {a,b} index to form the byte address (2 for 32-bit words)
AXI_AW, 32, AXI address width
AXI_DW, 32, AXI read data width
CNT_W, 16, width of the completed-read counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req0  in  1  requester 0 lookup request; held high until done0
a0  in  3  requester 0 operand a
b0  in  3  requester 0 operand b
done0  out  1  one-cycle pulse; result0/err0 valid this cycle
result0  out  6  requester 0 product, held until the next done0
err0  out  1  rresp != OKAY on requester 0's last read, held with result0
req1, a1, b1, done1, result1, err1  as above, for requester 1
busy  out  1  high while state != IDLE
rd_count  out  CNT_W  completed reads, saturating
m_araddr  out  AXI_AW  to s_axi_araddr
m_arvalid  out  1  to s_axi_arvalid
m_arready  in  1  from s_axi_arready
m_rdata  in  AXI_DW  from s_axi_rdata
m_rresp  in  2  from s_axi_rresp
m_rvalid  in  1  from s_axi_rvalid
m_rready  out  1  to s_axi_rready

Behaviour:
- Reset, synchronous: the block clears all outputs to 0 and sets state to IDLE. The last-grant pointer is set to 1, so requester 0 wins the first tie. The slave shares the same rst (s_aresetn = !rst).
- FSM states are IDLE, ADDR and DATA. Only one transaction is outstanding at a time.
- IDLE: when req0 or req1 is sampled high, the block selects one requester and registers owner, m_araddr = {zeros, a, b} << ADDR_SHIFT, and m_arvalid=1, then moves to ADDR.
  - Selection with one request: that requester.
  - Selection with both requests: the requester not equal to the last-grant pointer.
  - The pointer updates on grant.
- ADDR: m_arvalid and m_araddr stay stable until m_arready is sampled high. On that edge, m_arvalid goes to 0, m_rready goes to 1, and state moves to DATA. No timeout; AR stalls indefinitely if the slave never becomes ready.
- DATA: m_rready is held at 1. When m_rvalid is sampled high:
  - result<owner> <= m_rdata[5:0]
  - err<owner> <= (m_rresp != 0)
  - done<owner> = 1 for one cycle
  - m_rready <= 0
  - rd_count increments, saturating at all-ones
  - state returns to IDLE
- A response with an error still completes normally: the result is captured and err is set.
- Latency: with the slave ready immediately, m_arvalid asserts 1 cycle after req is sampled. done asserts at least 1 cycle after the AR handshake. Minimum req-to-done is 3 cycles.
- Back-to-back: in the done cycle the FSM is in IDLE. The requester must drop or refresh req, so a new grant is sampled no earlier than the cycle after done. If a req is still high on that edge, it is treated as a new request.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1.
- Request withdrawal:
  - A non-granted requester dropping req has no effect.
  - The granted requester dropping req mid-transaction: the AXI transaction still completes, and done/result still update.
- Operand changes on a, b while in ADDR or DATA are ignored, because the address is latched at grant.
- A reset asserted mid-transaction returns the block to IDLE immediately. Any partial handshake is abandoned; the slave is reset simultaneously.
- Only the upper bits of m_rdata are ignored; result is always m_rdata[5:0].

Test Plan:
- Single lookup: reset, req0 with a0=3, b0=5, slave arready/rvalid immediate, rdata=15 -> m_araddr=0x74, done0 pulses 3 cycles after req0, result0=15, err0=0, rd_count=1.
- Simultaneous contention: req0 (a=7, b=7) and req1 (a=2, b=6) asserted together from reset -> requester 0 is served first with result0=49, then requester 1 with result1=12; exactly one done pulse each, in order.
- Backpressure: arready held low 5 cycles, then rvalid delayed 4 cycles after the AR handshake -> m_arvalid/m_araddr are stable throughout the stall, m_rready stays high in DATA, and done1 fires exactly one cycle-edge after rvalid.
- Error response: rresp=2'b10 with rdata=0 for req1 -> done1 pulses, err1=1, result1=0. A following OKAY read clears err1 to 0.
- Reset mid-operation: rst asserted while in DATA -> next cycle busy=0, m_rready=0, m_arvalid=0, all results, errors and rd_count are 0, and no done pulse is produced.
- Saturation and fairness: force rd_count near its maximum (CNT_W=4) and run 20 alternating contested reads -> rd_count sticks at 15 and grants alternate strictly 0,1,0,1.

Source files
------------

// File: rtl/axi_timestable_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_timestable_arbiter
// Description : Round-robin arbiter sharing one AXI4-lite read path into the
//               times-table block memory between two lookup requesters.
//               Single outstanding AR/R transaction; 6-bit product returned
//               to the granted requester with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_timestable_arbiter #(
    parameter int ADDR_SHIFT = 2,
    parameter int AXI_AW     = 32,
    parameter int AXI_DW     = 32,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [2:0]        a0,
    input  logic [2:0]        b0,
    output logic              done0,
    output logic [5:0]        result0,
    output logic              err0,
    input  logic              req1,
    input  logic [2:0]        a1,
    input  logic [2:0]        b1,
    output logic              done1,
    output logic [5:0]        result1,
    output logic              err1,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_count,
    output logic [AXI_AW-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [AXI_DW-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t              r_state;
    state_t              w_state_next;
    logic                r_last;
    logic                r_owner;
    logic [AXI_AW-1:0]   r_araddr;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_done0;
    logic                r_done1;
    logic [5:0]          r_result0;
    logic [5:0]          r_result1;
    logic                r_err0;
    logic                r_err1;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_grant_valid;
    logic                w_grant_sel;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic [5:0]          w_sel_ab;
    logic [AXI_AW-1:0]   w_sel_addr;
    logic                w_rerr;
    logic                w_unused_rdata;

    // Index of the requester being granted, widened and scaled to a byte address
    assign w_sel_ab   = w_grant_sel ? {a1, b1} : {a0, b0};
    assign w_sel_addr = {{(AXI_AW-6){1'b0}}, w_sel_ab} << ADDR_SHIFT;
    assign w_rerr     = (m_rresp != 2'b00);

    // Only the low six bits of a table word carry the product
    assign w_unused_rdata = ^m_rdata[AXI_DW-1:6];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, grant selection and handshake strobes
    always_comb begin
        w_state_next  = r_state;
        w_grant_valid = 1'b0;
        w_grant_sel   = 1'b0;
        w_ar_hs       = 1'b0;
        w_r_hs        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_grant_valid = 1'b1;
                    // On a tie the requester not granted last time wins
                    w_grant_sel   = (req0 && req1) ? ~r_last : req1;
                    w_state_next  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_arready) begin
                    w_ar_hs      = 1'b1;
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_rvalid) begin
                    w_r_hs       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: grant capture, AXI control registers, result return, counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_result0 <= '0;
            r_result1 <= '0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (w_grant_valid) begin
                r_owner   <= w_grant_sel;
                r_last    <= w_grant_sel;
                r_araddr  <= w_sel_addr;
                r_arvalid <= 1'b1;
            end
            if (w_ar_hs) begin
                r_arvalid <= 1'b0;
                r_rready  <= 1'b1;
            end
            if (w_r_hs) begin
                r_rready <= 1'b0;
                if (r_cnt != c_cnt_max) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
                if (r_owner) begin
                    r_result1 <= m_rdata[5:0];
                    r_err1    <= w_rerr;
                    r_done1   <= 1'b1;
                end else begin
                    r_result0 <= m_rdata[5:0];
                    r_err0    <= w_rerr;
                    r_done0   <= 1'b1;
                end
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign rd_count  = r_cnt;
    assign m_araddr  = r_araddr;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign result0   = r_result0;
    assign result1   = r_result1;
    assign err0      = r_err0;
    assign err1      = r_err1;

endmodule
`default_nettype wire

// File: tb/tb_axi_timestable_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_timestable_arbiter
// Description : Directed self-checking bench for axi_timestable_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_timestable_arbiter;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             req0, req1;
    logic [2:0]       a0, b0, a1, b1;
    logic             done0, done1;
    logic [5:0]       result0, result1;
    logic             err0, err1;
    logic             busy;
    logic [CNT_W-1:0] rd_count;
    logic [31:0]      m_araddr;
    logic             m_arvalid;
    logic             m_arready;
    logic [31:0]      m_rdata;
    logic [1:0]       m_rresp;
    logic             m_rvalid;
    logic             m_rready;

    int checks;
    int failures;

    axi_timestable_arbiter #(
        .ADDR_SHIFT (2),
        .AXI_AW     (32),
        .AXI_DW     (32),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .done0     (done0),
        .result0   (result0),
        .err0      (err0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .done1     (done1),
        .result1   (result1),
        .err1      (err1),
        .busy      (busy),
        .rd_count  (rd_count),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // Stimulus helper: step until the selected done pulse is seen or budget expires
    task automatic wait_done(input logic which, input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if ((which ? done1 : done0) === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (m_arvalid !== 1'b0 || m_rready !== 1'b0) begin failures++; $display("FAIL reset_axi got arvalid=%0h rready=%0h exp=0", m_arvalid, m_rready); end
        checks++; if (m_araddr !== 32'h0) begin failures++; $display("FAIL reset_araddr got=%0h exp=0", m_araddr); end
        checks++; if ({done0, done1, err0, err1} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%0h exp=0", {done0, done1, err0, err1}); end
        checks++; if (result0 !== 6'd0 || result1 !== 6'd0 || rd_count !== 4'd0) begin failures++; $display("FAIL reset_data got r0=%0d r1=%0d cnt=%0d exp=0", result0, result1, rd_count); end
    endtask

    task automatic test_single();
        do_reset();
        req0 = 1; a0 = 3; b0 = 5;
        m_arready = 1; m_rvalid = 1; m_rdata = 32'd15; m_rresp = 0;
        tick();
        checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h74) begin failures++; $display("FAIL single_ar got arvalid=%0h addr=%0h exp 1/74", m_arvalid, m_araddr); end
        checks++; if (busy !== 1'b1 || done0 !== 1'b0) begin failures++; $display("FAIL single_busy got busy=%0h done0=%0h exp 1/0", busy, done0); end
        tick();
        checks++; if (m_arvalid !== 1'b0 || m_rready !== 1'b1 || done0 !== 1'b0) begin failures++; $display("FAIL single_data got arvalid=%0h rready=%0h done0=%0h exp 0/1/0", m_arvalid, m_rready, done0); end
        tick();
        checks++; if (done0 !== 1'b1 || done1 !== 1'b0) begin failures++; $display("FAIL single_done got done0=%0h done1=%0h exp 1/0", done0, done1); end
        checks++; if (result0 !== 6'd15 || err0 !== 1'b0 || rd_count !== 4'd1) begin failures++; $display("FAIL single_result got r=%0d err=%0h cnt=%0d exp 15/0/1", result0, err0, rd_count); end
        checks++; if (m_rready !== 1'b0) begin failures++; $display("FAIL single_rready_drop got=%0h exp=0", m_rready); end
        req0 = 0;
        tick();
        checks++; if (done0 !== 1'b0 || busy !== 1'b0 || result0 !== 6'd15) begin failures++; $display("FAIL single_after got done0=%0h busy=%0h r=%0d exp 0/0/15", done0, busy, result0); end
    endtask

    task automatic test_contention();
        int n0, n1, first;
        do_reset();
        n0 = 0; n1 = 0; first = -1;
        req0 = 1; a0 = 7; b0 = 7;
        req1 = 1; a1 = 2; b1 = 6;
        m_arready = 1; m_rvalid = 1; m_rdata = 32'd49; m_rresp = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0 === 1'b1) begin
                n0++;
                if (first < 0) first = 0;
                req0 = 0;
                m_rdata = 32'd12;
            end
            if (done1 === 1'b1) begin
                n1++;
                if (first < 0) first = 1;
                req1 = 0;
            end
        end
        checks++; if (first !== 0) begin failures++; $display("FAIL contend_order got first=%0d exp=0", first); end
        checks++; if (n0 !== 1 || n1 !== 1) begin failures++; $display("FAIL contend_pulses got n0=%0d n1=%0d exp 1/1", n0, n1); end
        checks++; if (result0 !== 6'd49 || result1 !== 6'd12) begin failures++; $display("FAIL contend_results got r0=%0d r1=%0d exp 49/12", result0, result1); end
        checks++; if (m_araddr !== 32'h58) begin failures++; $display("FAIL contend_addr1 got=%0h exp=58", m_araddr); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req1 = 1; a1 = 4; b1 = 5;
        m_arready = 0; m_rvalid = 0; m_rdata = 32'd20; m_rresp = 0;
        tick();
        checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h94) begin failures++; $display("FAIL bp_ar got arvalid=%0h addr=%0h exp 1/94", m_arvalid, m_araddr); end
        // Operands moving during the stall must not disturb the latched address
        a1 = 0; b1 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h94 || busy !== 1'b1) begin failures++; $display("FAIL bp_ar_stall cyc=%0d got arvalid=%0h addr=%0h busy=%0h exp 1/94/1", i, m_arvalid, m_araddr, busy); end
        end
        m_arready = 1;
        tick();
        m_arready = 0;
        checks++; if (m_arvalid !== 1'b0 || m_rready !== 1'b1) begin failures++; $display("FAIL bp_ar_hs got arvalid=%0h rready=%0h exp 0/1", m_arvalid, m_rready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (m_rready !== 1'b1 || done1 !== 1'b0) begin failures++; $display("FAIL bp_r_stall cyc=%0d got rready=%0h done1=%0h exp 1/0", i, m_rready, done1); end
        end
        m_rvalid = 1;
        tick();
        m_rvalid = 0;
        req1 = 0;
        checks++; if (done1 !== 1'b1 || result1 !== 6'd20 || err1 !== 1'b0) begin failures++; $display("FAIL bp_done got done1=%0h r=%0d err=%0h exp 1/20/0", done1, result1, err1); end
        tick();
        checks++; if (done1 !== 1'b0 || m_rready !== 1'b0) begin failures++; $display("FAIL bp_after got done1=%0h rready=%0h exp 0/0", done1, m_rready); end
    endtask

    task automatic test_error();
        logic seen;
        req1 = 1; a1 = 1; b1 = 1;
        m_arready = 1; m_rvalid = 1; m_rresp = 2'b10; m_rdata = 32'd0;
        wait_done(1'b1, 8, seen);
        req1 = 0;
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL err_timeout got seen=%0h exp=1", seen); end
        checks++; if (err1 !== 1'b1 || result1 !== 6'd0) begin failures++; $display("FAIL err_resp got err=%0h r=%0d exp 1/0", err1, result1); end
        tick();
        checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL err_hold got=%0h exp=1", err1); end
        req1 = 1; a1 = 6; b1 = 7;
        m_rresp = 2'b00; m_rdata = 32'd42;
        wait_done(1'b1, 8, seen);
        req1 = 0;
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL err_ok_timeout got seen=%0h exp=1", seen); end
        checks++; if (err1 !== 1'b0 || result1 !== 6'd42 || rd_count !== 4'd3) begin failures++; $display("FAIL err_clear got err=%0h r=%0d cnt=%0d exp 0/42/3", err1, result1, rd_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        req0 = 1; a0 = 2; b0 = 3;
        m_arready = 1; m_rvalid = 1; m_rresp = 2'b10; m_rdata = 32'd6;
        wait_done(1'b0, 8, seen);
        req0 = 0;
        checks++; if (seen !== 1'b1 || result0 !== 6'd6 || err0 !== 1'b1) begin failures++; $display("FAIL rmid_pre got seen=%0h r=%0d err=%0h exp 1/6/1", seen, result0, err0); end
        tick();
        m_rvalid = 0;
        req0 = 1;
        tick();
        tick();
        checks++; if (m_rready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rmid_in_data got rready=%0h busy=%0h exp 1/1", m_rready, busy); end
        rst = 1; m_rvalid = 1;
        tick();
        checks++; if (busy !== 1'b0 || m_rready !== 1'b0 || m_arvalid !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got busy=%0h rready=%0h arvalid=%0h exp 0/0/0", busy, m_rready, m_arvalid); end
        checks++; if (result0 !== 6'd0 || err0 !== 1'b0 || rd_count !== 4'd0 || done0 !== 1'b0) begin failures++; $display("FAIL rmid_data got r=%0d err=%0h cnt=%0d done=%0h exp 0", result0, err0, rd_count, done0); end
        rst = 0; req0 = 0; m_rvalid = 0;
        tick();
        checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL rmid_nodone got done0=%0h done1=%0h exp 0/0", done0, done1); end
    endtask

    task automatic test_saturation_fairness();
        int n;
        int exp_owner;
        int exp_cnt;
        do_reset();
        n = 0; exp_owner = 0;
        req0 = 1; a0 = 1; b0 = 2;
        req1 = 1; a1 = 3; b1 = 4;
        m_arready = 1; m_rvalid = 1; m_rresp = 0;
        m_rdata = 32'hFFFF_FFC0 | 32'd10;
        for (int i = 0; i < 90 && n < 20; i++) begin
            tick();
            if (done0 === 1'b1 || done1 === 1'b1) begin
                exp_cnt = (n + 1 < 15) ? n + 1 : 15;
                checks++;
                if (done0 !== (exp_owner == 0) || done1 !== (exp_owner == 1)) begin
                    failures++; $display("FAIL fair_owner read=%0d got done0=%0h done1=%0h exp_owner=%0d", n, done0, done1, exp_owner);
                end
                checks++;
                if ((exp_owner == 0 ? result0 : result1) !== 6'(10 + n) || rd_count !== 4'(exp_cnt)) begin
                    failures++; $display("FAIL fair_data read=%0d got r0=%0d r1=%0d cnt=%0d exp r=%0d cnt=%0d", n, result0, result1, rd_count, 10 + n, exp_cnt);
                end
                n++;
                exp_owner = 1 - exp_owner;
                m_rdata = 32'hFFFF_FFC0 | 32'(10 + n);
            end
        end
        req0 = 0; req1 = 0;
        checks++; if (n !== 20) begin failures++; $display("FAIL fair_timeout got reads=%0d exp=20", n); end
        checks++; if (rd_count !== 4'd15) begin failures++; $display("FAIL sat_count got=%0d exp=15", rd_count); end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_saturation_fairness();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
